// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan path: digit codes, segment bit order,
// glyph table and scan state encoding.
package fnd_pkg;

  localparam logic [3:0] FND_BLANK = 4'd10;
  localparam logic [3:0] FND_DASH  = 4'd11;

  // Segment bit positions within the 8-bit segment word {dp,g,f,e,d,c,b,a}
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // Active-high {g,f,e,d,c,b,a} glyph for a digit code; unused codes are blank
  function automatic logic [6:0] fnd_glyph(input logic [3:0] code);
    logic [6:0] g;
    g = '0;
    case (code)
      4'd0:     g = 7'h3F;
      4'd1:     g = 7'h06;
      4'd2:     g = 7'h5B;
      4'd3:     g = 7'h4F;
      4'd4:     g = 7'h66;
      4'd5:     g = 7'h6D;
      4'd6:     g = 7'h7D;
      4'd7:     g = 7'h07;
      4'd8:     g = 7'h7F;
      4'd9:     g = 7'h6F;
      FND_DASH: g = 7'h40;
      default:  g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational digit-code to active-high segment decoder.
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  // Look up the glyph and attach the decimal point
  always_comb begin
    seg = '0;
    seg[SEG_G:SEG_A] = fnd_glyph(code);
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-pin 7-segment array with
// per-slot dead-time blanking and a per-frame shadow copy of the digit data.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 10000,
  parameter int unsigned BLANK_CYC  = 100,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   digit_data,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [NUM_DIGITS-1:0]     fnd_com,
  output logic [7:0]                fnd_seg,
  output logic [2:0]                slot_idx,
  output logic                      frame_done
);

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W:0]   BLANK_TH  = (CNT_W + 1)'(BLANK_CYC);
  localparam logic [2:0]       LAST_SLOT = 3'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] COM_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [7:0]            SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

  // With no dead time a new slot starts straight in DRIVE
  localparam scan_state_e WRAP_STATE = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W:0]          cnt_inc;
  logic [2:0]              slot_q, slot_d;
  logic [DATA_W-1:0]       shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic [7:0]              seg_q, seg_d;

  logic [3:0]              dec_code;
  logic                    dec_dp;
  logic [7:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   com_onehot;

  // Scan sequencing: slot counter, slot index, frame wrap and shadow reload
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    frame_done_d = 1'b0;
    cnt_inc      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      slot_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_BLANK;
          cnt_d       = '0;
          slot_d      = '0;
          shadow_d    = digit_data;
          shadow_dp_d = dp_mask;
        end
        default: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            state_d = WRAP_STATE;
            if (slot_q < LAST_SLOT) begin
              slot_d = slot_q + 3'd1;
            end else begin
              slot_d       = '0;
              shadow_d     = digit_data;
              shadow_dp_d  = dp_mask;
              frame_done_d = 1'b1;
            end
          end else begin
            cnt_d   = cnt_inc[CNT_W-1:0];
            state_d = (cnt_inc >= BLANK_TH) ? ST_DRIVE : ST_BLANK;
          end
        end
      endcase
    end
  end

  // Select the next slot's code and dp from the next-cycle shadow, so the
  // registered outputs line up with the state they are loaded alongside
  always_comb begin
    dec_code   = FND_BLANK;
    dec_dp     = 1'b0;
    com_onehot = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (slot_d == 3'(k)) begin
        dec_code      = shadow_d[4*k +: 4];
        dec_dp        = shadow_dp_d[k];
        com_onehot[k] = 1'b1;
      end
    end
  end

  fnd_seg_decode u_seg_decode (
    .code (dec_code),
    .dp   (dec_dp),
    .seg  (dec_seg)
  );

  // Pin drive: only in DRIVE, with polarity applied here
  always_comb begin
    com_d = COM_OFF;
    seg_d = SEG_OFF;
    if (en && state_d == ST_DRIVE) begin
      com_d = ACTIVE_LOW ? ~com_onehot : com_onehot;
      seg_d = ACTIVE_LOW ? ~dec_seg : dec_seg;
    end
  end

  // State, shadow and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      slot_q       <= '0;
      shadow_q     <= {NUM_DIGITS{FND_BLANK}};
      shadow_dp_q  <= '0;
      frame_done_q <= 1'b0;
      com_q        <= COM_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      frame_done_q <= frame_done_d;
      com_q        <= com_d;
      seg_q        <= seg_d;
    end
  end

  assign fnd_com    = com_q;
  assign fnd_seg    = seg_q;
  assign slot_idx   = slot_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
- Time-multiplexed scan controller for the snake game's common-pin 7-segment (FND) array.
- Takes packed 4-bit digit codes from the score, speed and level digit converters and drives one digit position at a time.
- Inserts a dead-time blank at the start of each slot to suppress ghosting.
- Double-buffers the digit data per frame so a display never tears mid-scan.

Parameters:
- NUM_DIGITS, 8, number of digit positions scanned (2..8).
- SCAN_DIV, 10000, clock cycles per digit slot (>= 2).
- BLANK_CYC, 100, dead-time cycles at the start of each slot (0 <= BLANK_CYC < SCAN_DIV).
- ACTIVE_LOW, 1, when 1, fnd_com and fnd_seg are active-low at the pins.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  scan enable; 0 turns the display off.
- digit_data  input  4*NUM_DIGITS  digit codes; digit k occupies bits [4k+3:4k], and digit 0 is the rightmost position.
- dp_mask  input  NUM_DIGITS  decimal point enable per digit.
- fnd_com  output  NUM_DIGITS  digit common selects, one-hot when driving.
- fnd_seg  output  8  segments {dp,g,f,e,d,c,b,a}.
- slot_idx  output  3  index of the slot currently being scanned.
- frame_done  output  1  one-cycle pulse when the frame wraps.

Behaviour:
- Reset (synchronous, active-high), values take effect at the next edge:
  - state=IDLE, cnt=0, slot_idx=0, frame_done=0.
  - Shadow digits all = 10 (blank); shadow dp = 0.
  - fnd_com and fnd_seg inactive: all 1s if ACTIVE_LOW, else all 0s.
  - rst overrides en, including mid-frame.
- Digit codes:
  - 0-9 are decimal glyphs.
  - 10 is blank.
  - 11 is '-' (segment g only).
  - 12-15 are blank.
  - dp is lit only when the shadow dp bit is set and the slot is driving.
- State machine, states IDLE, BLANK and DRIVE:
  - IDLE with en=1: next state=BLANK, cnt=0, slot_idx=0, shadow <= digit_data/dp_mask.
  - BLANK/DRIVE with en=1: cnt increments. Next state is DRIVE when cnt+1 >= BLANK_CYC, else BLANK.
  - With BLANK_CYC=0, BLANK is never entered after the first cycle of a slot, i.e. a slot is all DRIVE apart from the IDLE exit.
  - When cnt==SCAN_DIV-1: cnt <= 0 and the state goes to BLANK (or DRIVE if BLANK_CYC=0).
    - If slot_idx < NUM_DIGITS-1, slot_idx increments.
    - Otherwise slot_idx <= 0, shadow is reloaded from the inputs, and frame_done <= 1 for exactly one cycle.
  - en=0 in any state: next state=IDLE, cnt=0, slot_idx=0. The shadow is held, and no frame_done is generated.
- Output register:
  - fnd_com/fnd_seg are registered.
  - At each edge they load inactive if rst or en=0 is sampled, or if the next state is not DRIVE.
  - Otherwise they load the decode of shadow[next slot_idx] with com bit next slot_idx active.
  - As a result, the outputs change on the same edge as the state and are never driven during BLANK.
- Inputs are sampled only at a frame wrap or on IDLE exit. Changes to digit_data mid-frame are invisible until the next frame.
- Width rule: slot_idx is 3 bits and zero-extended. cnt is $clog2(SCAN_DIV) bits and never exceeds SCAN_DIV-1.

Decomposition:
- Shared package/header fnd_pkg holds:
  - code constants FND_BLANK=4'd10 and FND_DASH=4'd11;
  - the 7-bit glyph table for 0-9 and '-';
  - the segment bit-order definition.
- One combinational sub-module, fnd_seg_decode: input 4-bit code plus dp, output 8-bit active-high segments.
- Polarity inversion is done only in fnd_scan_ctrl.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1.
1. Reset then en=1, digit_data=16'hA_A_0_7 (digits 3..0 = blank, blank, 0, 7) -> after IDLE exit, slot 0 has 2 cycles with fnd_com=4'b1111, then 6 cycles with fnd_com=4'b1110 and fnd_seg=~8'h07; slot 1 shows '0' (~8'h3F) on 4'b1101; slots 2-3 drive com with fnd_seg all 1s.
2. Frame wrap -> frame_done high exactly one cycle, 32 cycles after the IDLE exit. digit_data changed at cycle 10 appears only after the wrap.
3. en dropped during DRIVE of slot 2 -> fnd_com=4'b1111 and fnd_seg=8'hFF at the next edge, slot_idx=0 and no frame_done. Re-enabling restarts at slot 0 with a fresh snapshot.
4. rst asserted mid-DRIVE with en=1 -> all outputs inactive and shadow blank at the next edge. After release the scan restarts from slot 0.
5. Codes 11, 12, 15 with dp_mask=4'b0001 -> slot 0 shows ~8'hC0 ('-' plus dp); codes 12 and 15 show 8'hFF.
6. BLANK_CYC=0 build -> com active on all 8 cycles of every slot after the first, with no inactive gap between consecutive slots.
